// File: rtl/uart_tx_fifo_ctrl.sv
// uart_tx_fifo_ctrl: THR holding FIFO and sequencer between the register file and the UART transmitter
module uart_tx_fifo_ctrl #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              pclk_i,
    input  logic              preset_i,
    input  logic              utrst_i,
    input  logic              fifo_en_i,
    input  logic              thr_wr_i,
    input  logic [DATA_W-1:0] thr_wdata_i,
    input  logic              tsr_load_i,
    input  logic              tx_frame_done_i,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              thre_o,
    output logic              temt_o,
    output logic [ADDR_W:0]   fifo_count_o,
    output logic              thr_ovf_o,
    output logic              thre_rise_o
);
    localparam logic [ADDR_W:0] CAP_FIFO = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] CAP_HOLD = (ADDR_W+1)'(1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d, cap;
    logic              tx_busy_q, tx_busy_d, thre_q, fifo_en_q, thr_ovf_q, thr_ovf_d;
    logic              empty, full, flush, pop, wr;

    // Occupancy decode, flush detection and next-state for pointers, count, busy and overflow
    always_comb begin
        cap       = fifo_en_i ? CAP_FIFO : CAP_HOLD;
        empty     = count_q == '0;
        full      = count_q == cap;
        flush     = utrst_i | (fifo_en_i != fifo_en_q);
        pop       = tsr_load_i & ~empty & ~flush;
        wr        = thr_wr_i & (~full | pop) & ~flush;
        thr_ovf_d = thr_wr_i & full & ~pop & ~flush;
        wr_ptr_d  = flush ? '0 : wr ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d  = flush ? '0 : pop ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d   = flush ? '0 : count_q + (ADDR_W+1)'(wr) - (ADDR_W+1)'(pop);
        tx_busy_d = utrst_i ? 1'b0 : pop ? 1'b1 : tx_frame_done_i ? 1'b0 : tx_busy_q;
    end

    // Control state; thre_q remembers last cycle's thre so a flush of a full buffer still reports a rise
    always_ff @(posedge pclk_i) begin
        fifo_en_q <= fifo_en_i;
        if (preset_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            tx_busy_q <= 1'b0;
            thre_q    <= 1'b1;
            thr_ovf_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            tx_busy_q <= tx_busy_d;
            thre_q    <= thre_o;
            thr_ovf_q <= thr_ovf_d;
        end
    end

    // Storage array, written only by accepted writes and never reset
    always_ff @(posedge pclk_i) begin
        if (!preset_i && wr) mem_q[wr_ptr_q] <= thr_wdata_i;
    end

    assign tx_data_o    = empty ? '0 : mem_q[rd_ptr_q];
    assign thre_o       = empty;
    assign temt_o       = empty & ~tx_busy_q;
    assign fifo_count_o = count_q;
    assign thr_ovf_o    = thr_ovf_q;
    assign thre_rise_o  = thre_o & ~thre_q;
endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// tb_uart_tx_fifo_ctrl: scoreboard bench for the THR FIFO controller
module tb_uart_tx_fifo_ctrl;
    logic       clk = 1'b0;
    logic       preset, utrst, fifo_en, thr_wr, tsr_load, fd;
    logic [7:0] wd;
    logic [7:0] tx_data;
    logic       thre, temt, thr_ovf, thre_rise;
    logic [4:0] fifo_count;

    int         total = 0, bad = 0;
    logic [7:0] exp_q [$];
    int         m_cnt;
    bit         m_busy, m_en;

    always #5 clk = ~clk;

    uart_tx_fifo_ctrl #(.DEPTH(16), .ADDR_W(4), .DATA_W(8)) dut (
        .pclk_i(clk), .preset_i(preset), .utrst_i(utrst), .fifo_en_i(fifo_en),
        .thr_wr_i(thr_wr), .thr_wdata_i(wd), .tsr_load_i(tsr_load), .tx_frame_done_i(fd),
        .tx_data_o(tx_data), .thre_o(thre), .temt_o(temt), .fifo_count_o(fifo_count),
        .thr_ovf_o(thr_ovf), .thre_rise_o(thre_rise)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: w=write d, ld=tsr_load, f=frame done, u=utrst, en=fifo_en level
    task automatic op(input bit w, input logic [7:0] d, input bit ld, input bit f, input bit u, input bit en);
        bit flush, pop, acc, ovf, pre_thre;
        int cap;
        pre_thre = (m_cnt == 0);
        cap      = en ? 16 : 1;
        flush    = u || (en != m_en);
        pop      = !flush && ld && m_cnt > 0;
        acc      = !flush && w && (m_cnt < cap || pop);
        ovf      = !flush && w && m_cnt == cap && !pop;
        if (pop) check("tx_pop", tx_data, exp_q.pop_front());
        if (flush) exp_q.delete();
        else if (acc) exp_q.push_back(d);
        m_cnt  = exp_q.size();
        m_busy = u ? 1'b0 : pop ? 1'b1 : f ? 1'b0 : m_busy;
        m_en   = en;
        thr_wr = w; wd = d; tsr_load = ld; fd = f; utrst = u; fifo_en = en;
        @(posedge clk); #1;
        thr_wr = 0; tsr_load = 0; fd = 0; utrst = 0;
        check("count", fifo_count, m_cnt);
        check("ovf", thr_ovf, ovf);
        check("thre", thre, m_cnt == 0);
        check("temt", temt, m_cnt == 0 && !m_busy);
        check("thre_rise", thre_rise, !pre_thre && m_cnt == 0);
        if (m_cnt == 0) check("tx_idle", tx_data, 0);
    endtask

    initial begin
        preset = 1; utrst = 0; fifo_en = 1; thr_wr = 0; wd = 0; tsr_load = 0; fd = 0;
        m_cnt = 0; m_busy = 0; m_en = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_thre", thre, 1);
        check("rst_temt", temt, 1);
        check("rst_count", fifo_count, 0);
        check("rst_data", tx_data, 0);
        check("rst_ovf", thr_ovf, 0);
        check("rst_rise", thre_rise, 0);
        preset = 0;
        // fill, overflow, drain
        for (int i = 1; i <= 16; i++) op(1, 8'(i), 0, 0, 0, 1);
        op(1, 8'h11, 0, 0, 0, 1);
        for (int i = 0; i < 16; i++) op(0, 0, 1, 0, 0, 1);
        op(0, 0, 0, 1, 0, 1);
        // holding-register mode
        op(0, 0, 0, 0, 0, 0);
        op(1, 8'hA5, 0, 0, 0, 0);
        check("hold_head", tx_data, 8'hA5);
        op(1, 8'h5A, 0, 0, 0, 0);
        op(1, 8'h3C, 1, 0, 0, 0);
        check("hold_repl", tx_data, 8'h3C);
        op(0, 0, 1, 0, 0, 0);
        op(0, 0, 0, 1, 0, 0);
        // wrap-around at steady occupancy 3
        op(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) op(1, 8'(8'h40 + i), 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) op(1, 8'(8'h50 + i), 1, 0, 0, 1);
        op(0, 0, 1, 0, 0, 1);
        op(0, 0, 1, 0, 0, 1);
        op(0, 0, 1, 1, 0, 1);
        op(0, 0, 0, 1, 0, 1);
        // full with simultaneous write and pop
        for (int i = 0; i < 16; i++) op(1, 8'(8'h80 + i), 0, 0, 0, 1);
        op(1, 8'hAA, 1, 0, 0, 1);
        for (int i = 0; i < 11; i++) op(0, 0, 1, 0, 0, 1);
        // flush by utrst with 5 entries and transmitter busy
        op(0, 0, 0, 0, 1, 1);
        for (int i = 0; i < 6; i++) op(1, 8'(8'hC0 + i), 0, 0, 0, 1);
        op(0, 0, 1, 0, 0, 1);
        // flush by fifo_en toggle with a same-cycle write
        op(1, 8'hEE, 0, 0, 0, 0);
        op(0, 0, 0, 1, 0, 0);
        op(0, 0, 0, 0, 0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
